cluster_cg_ctrl: RTL
====================

# cluster_cg_ctrl

Clock-gating controller for the cluster. It decides when the cluster clock may be stopped, sequences the clock-gate enable through an idle-hysteresis counter and a gate/ungate handshake, and wakes the cluster on demand from external requesters. It grants those requesters one at a time, round-robin. It runs on the ungated cluster clock, drives the cluster clock gate's enable and incoming-request inputs, and observes the gate's isolation status.

## Interface
- `NB_CORES`, 4, number of core busy lines
- `NB_REQ`, 2, number of external wake requesters (≥1)
- `CNT_WIDTH`, 8, width of the idle-hysteresis counter and its threshold
- `clk_i`  in  1  ungated cluster clock
- `rstn_i`  in  1  reset, asynchronous, active-low
- `cfg_en_i`  in  1  software enable for clock gating; quasi-static
- `cfg_idle_cycles_i`  in  CNT_WIDTH  idle cycles required before gating; quasi-static
- `cores_busy_i`  in  NB_CORES  per-core busy
- `cluster_int_busy_i`  in  1  interconnect/DMA busy
- `events_i`  in  1  asynchronous event line; synchronized internally with 2 flops
- `wake_req_i`  in  NB_REQ  wake/access request per requester; level, held until acked
- `wake_ack_o`  out  NB_REQ  one-cycle ack pulse, one-hot or zero
- `gated_i`  in  1  high while the downstream cluster clock is stopped or isolated
- `cg_en_o`  out  1  clock-gate enable request to the gate
- `incoming_req_o`  out  1  combinational `|wake_req_i`; holds the gate open
- `sleeping_o`  out  1  high in state GATED

## Operation
- Definitions:
  - `busy` = `cluster_int_busy_i | (|cores_busy_i)`
  - `ev` = synchronized `events_i` (2nd flop)
  - `anyreq` = `|wake_req_i`
  - `idle` = `cfg_en_i & ~busy & ~ev & ~anyreq`
  - `wake` = `~idle`
- FSM states: RUN, GATE_REQ, GATED, WAKE. Reset state is RUN.
- **RUN:** the 8-bit (`CNT_WIDTH`) counter `cnt` increments while `idle`.
  - It clears to 0 on any non-idle cycle.
  - It saturates and never wraps.
  - If `idle` and `cnt == cfg_idle_cycles_i`, go to GATE_REQ and clear `cnt`.
  - With `cfg_idle_cycles_i == 0`, this happens on the first idle cycle.
- **GATE_REQ:** `cg_en_o = 1`.
  - If `wake`, go to RUN.
  - Else if `gated_i`, go to GATED.
  - If both hold in the same cycle, `wake` wins: go to WAKE, not RUN, because the gate has already closed.
- **GATED:** `cg_en_o = 1`, `sleeping_o = 1`. If `wake`, go to WAKE.
- **WAKE:** `cg_en_o = 0`. When `gated_i == 0`, go to RUN. No timeout.
- **Arbitration:**
  - Acks are issued only in RUN, at most one per cycle.
  - The grant goes to the first requesting index at or after the round-robin pointer `ptr`, modulo `NB_REQ`.
  - After a grant, `ptr` moves to the granted index + 1, modulo `NB_REQ`.
  - A requester deasserts `wake_req_i` the cycle after it sees `wake_ack_o`. A request still high after its ack is treated as a new request.
- **Outputs:** `cg_en_o`, `sleeping_o` and `wake_ack_o` are registered. `incoming_req_o` is combinational.
- **Clearing `cfg_en_i`:** this forces `wake` in every state, so the gate reopens.

## Timing
- Reset values:
  - `cg_en_o` = 0, `sleeping_o` = 0, `wake_ack_o` = 0
  - `cnt` = 0, `ptr` = 0, state = RUN
  - both sync flops = 0
- Gating latency: counting from the first idle cycle, `cg_en_o` rises after `cfg_idle_cycles_i` + 1 edges.
- Event latency: a change on `events_i` reaches the FSM after 2 edges.
- Ack latency: in RUN, a request sampled at edge N produces `wake_ack_o` high during cycle N+1.
- Wake from GATED: the `wake` cycle moves the FSM to WAKE and drops `cg_en_o` on the next edge. The ack follows 1 cycle after RUN is re-entered.
- Reset asserted mid-operation: all state returns to reset values asynchronously. `cg_en_o` drops at once, so the gate reopens.

## Test plan
- **Gate entry:** `cfg_en=1`, `cfg_idle_cycles=3`, all inputs quiet → `cg_en_o` rises on the 4th edge. Then `gated_i=1` → `sleeping_o=1` the next cycle.
- **Hysteresis abort:** `cfg_idle_cycles=5`, pulse `cores_busy_i[2]` high at idle cycle 3 → `cnt` resets and `cg_en_o` stays 0. Gating happens 6 edges after busy drops.
- **Wake by request:** in GATED, raise `wake_req_i=2'b10`.
  - Required: `incoming_req_o=1` immediately; `cg_en_o=0` next cycle.
  - Drop `gated_i` 4 cycles later → state RUN, then `wake_ack_o=2'b10` for exactly 1 cycle.
- **Round-robin:** in RUN with `ptr=0`, hold `wake_req_i=2'b11`, with each requester dropping after its ack → acks `01` then `10`. Repeat with `ptr=1` → `10` then `01`.
- **Race:** in GATE_REQ, assert `gated_i` and `ev` in the same cycle → state WAKE, `cg_en_o=0`, never RUN while `gated_i=1`.
- **Config/reset:** clear `cfg_en_i` in GATED → WAKE, then RUN after `gated_i` falls. Assert `rstn_i` low in GATE_REQ → `cg_en_o=0` asynchronously, state RUN.

Source files
------------

// File: rtl/cluster_cg_ctrl.sv
// Cluster clock-gating controller: idle hysteresis, gate/ungate handshake with the
// cluster clock gate, and round-robin wake/access acknowledgement for external requesters.
module cluster_cg_ctrl #(
  parameter int NB_CORES  = 4,
  parameter int NB_REQ    = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic [CNT_WIDTH-1:0] cfg_idle_cycles_i,
  input  logic [NB_CORES-1:0]  cores_busy_i,
  input  logic                 cluster_int_busy_i,
  input  logic                 events_i,
  input  logic [NB_REQ-1:0]    wake_req_i,
  output logic [NB_REQ-1:0]    wake_ack_o,
  input  logic                 gated_i,
  output logic                 cg_en_o,
  output logic                 incoming_req_o,
  output logic                 sleeping_o
);

  localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_GATE_REQ = 2'd1;
  localparam logic [1:0] ST_GATED    = 2'd2;
  localparam logic [1:0] ST_WAKE     = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NB_REQ-1:0]    ack_q, ack_d;
  logic                 ev_s1_q, ev_s2_q;
  logic                 cg_en_q, cg_en_d;
  logic                 sleeping_q, sleeping_d;

  logic                 busy, anyreq, idle, wake;
  logic [NB_REQ-1:0]    req_m;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand;

  assign busy   = cluster_int_busy_i | (|cores_busy_i);
  assign anyreq = |wake_req_i;
  assign idle   = cfg_en_i & ~busy & ~ev_s2_q & ~anyreq;
  assign wake   = ~idle;

  // A requester keeps its line high during its ack cycle; that cycle must not re-grant it.
  generate
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_req_mask
      assign req_m[gi] = wake_req_i[gi] & ~ack_q[gi];
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NB_REQ);
      if (!grant_found && req_m[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    ack_d = '0;
    ptr_d = ptr_q;
    if (state_q == ST_RUN && grant_found) begin
      ack_d[grant_idx] = 1'b1;
      ptr_d = (grant_idx == PTR_W'(NB_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_RUN: begin
        if (idle) begin
          if (cnt_q == cfg_idle_cycles_i) begin
            state_d = ST_GATE_REQ;
          end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      ST_GATE_REQ: begin
        // Gate may already have closed in the same cycle the wake arrives.
        if (wake) begin
          state_d = gated_i ? ST_WAKE : ST_RUN;
        end else if (gated_i) begin
          state_d = ST_GATED;
        end
      end
      ST_GATED: begin
        if (wake) begin
          state_d = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (!gated_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign cg_en_d    = (state_d == ST_GATE_REQ) | (state_d == ST_GATED);
  assign sleeping_d = (state_d == ST_GATED);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      ptr_q      <= '0;
      ack_q      <= '0;
      ev_s1_q    <= 1'b0;
      ev_s2_q    <= 1'b0;
      cg_en_q    <= 1'b0;
      sleeping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      ack_q      <= ack_d;
      ev_s1_q    <= events_i;
      ev_s2_q    <= ev_s1_q;
      cg_en_q    <= cg_en_d;
      sleeping_q <= sleeping_d;
    end
  end

  assign cg_en_o        = cg_en_q;
  assign sleeping_o     = sleeping_q;
  assign wake_ack_o     = ack_q;
  assign incoming_req_o = anyreq;

endmodule
